// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the write-back stage: load formats, fixed register
// indices and default datapath widths.
package wb_regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NREGS_DEF  = 32;

    localparam logic [ADDR_W_DEF-1:0] LINK_REG = 5'd31;
    localparam logic [ADDR_W_DEF-1:0] ZERO_REG = 5'd0;

    // Load format selected by the LoadData field of the MEM/WB register.
    typedef enum logic [1:0] {
        LD_WORD  = 2'b00,
        LD_HALF  = 2'b01,
        LD_BYTE  = 2'b10,
        LD_UBYTE = 2'b11
    } load_fmt_e;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB pipeline-register bundle, decode-stage read ports and the
// commit observation outputs of the write-back stage.
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);

    // MEM/WB pipeline register contents
    logic [DATA_W-1:0] MemReadData;
    logic [DATA_W-1:0] ALUResult;
    logic [ADDR_W-1:0] RegAddress;
    logic [DATA_W-1:0] PCAdderResult;
    logic              RegWrite;
    logic              MemToReg;
    logic [1:0]        LoadData;
    logic              JrAddress;
    logic              JrData;

    // Decode-stage read ports
    logic [ADDR_W-1:0] ReadRegister1;
    logic [ADDR_W-1:0] ReadRegister2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;

    // Commit observation
    logic [DATA_W-1:0] LastWriteData;
    logic [ADDR_W-1:0] LastWriteReg;
    logic [DATA_W-1:0] WriteCount;

    modport master (
        output MemReadData, ALUResult, RegAddress, PCAdderResult,
        output RegWrite, MemToReg, LoadData, JrAddress, JrData,
        output ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2,
        input  LastWriteData, LastWriteReg, WriteCount
    );

    modport slave (
        input  MemReadData, ALUResult, RegAddress, PCAdderResult,
        input  RegWrite, MemToReg, LoadData, JrAddress, JrData,
        input  ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2,
        output LastWriteData, LastWriteReg, WriteCount
    );

endinterface

// File: rtl/wb_regfile_load_formatter.sv
// Little-endian sub-word load formatter: picks the addressed halfword or
// byte out of the loaded word and sign- or zero-extends it.
module wb_regfile_load_formatter
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic [1:0]        i_offset,
    input  load_fmt_e         i_load_fmt,
    output logic [DATA_W-1:0] o_data
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Halfword lane comes from offset bit 1 only; bit 0 is ignored for halfwords.
    assign w_half = i_mem_data[{i_offset[1], 4'b0000} +: 16];
    assign w_byte = i_mem_data[{i_offset, 3'b000} +: 8];

    // Extend the selected lane according to the load format.
    always_comb begin
        o_data = i_mem_data;
        case (i_load_fmt)
            LD_WORD:  o_data = i_mem_data;
            LD_HALF:  o_data = {{(DATA_W-16){w_half[15]}}, w_half};
            LD_BYTE:  o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            LD_UBYTE: o_data = {{(DATA_W-8){1'b0}}, w_byte};
            default:  o_data = i_mem_data;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value, commits it to the
// general register file and serves two bypassed read ports to decode.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int LINK_REG = int'(wb_regfile_pkg::LINK_REG)
) (
    input  logic         Clk,
    input  logic         Reset,
    wb_regfile_if.slave  bus
);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [DATA_W-1:0] r_last_data;
    logic [ADDR_W-1:0] r_last_reg;
    logic [DATA_W-1:0] r_write_count;

    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_wdata;
    logic [ADDR_W-1:0] w_waddr;
    logic              w_commit;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    wb_regfile_load_formatter #(
        .DATA_W (DATA_W)
    ) u_load_formatter (
        .i_mem_data (bus.MemReadData),
        .i_offset   (bus.ALUResult[1:0]),
        .i_load_fmt (load_fmt_e'(bus.LoadData)),
        .o_data     (w_load_data)
    );

    // jal/jalr redirect the destination to the link register.
    assign w_waddr = bus.JrAddress ? ADDR_W'(LINK_REG) : bus.RegAddress;

    // Write-back source in priority order: link value, formatted load, ALU.
    always_comb begin
        w_wdata = bus.ALUResult;
        if (bus.JrData) begin
            w_wdata = bus.PCAdderResult;
        end else if (bus.MemToReg) begin
            w_wdata = w_load_data;
        end
    end

    // Reset gating keeps the bypass from forwarding a write that reset will drop.
    assign w_commit = Reset && bus.RegWrite && (w_waddr != ADDR_W'(ZERO_REG));

    // Register array; entry 0 is never written so it stays zero.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[w_waddr] <= w_wdata;
        end
    end

    // Last-commit observation registers and the wrapping commit counter.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_last_data   <= '0;
            r_last_reg    <= '0;
            r_write_count <= '0;
        end else if (w_commit) begin
            r_last_data   <= w_wdata;
            r_last_reg    <= w_waddr;
            r_write_count <= r_write_count + 1'b1;
        end
    end

    // Read port 1: zero register, then write-through bypass, then array.
    always_comb begin
        w_rd1 = r_regs[bus.ReadRegister1];
        if (bus.ReadRegister1 == ADDR_W'(ZERO_REG)) begin
            w_rd1 = '0;
        end else if (w_commit && (bus.ReadRegister1 == w_waddr)) begin
            w_rd1 = w_wdata;
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        w_rd2 = r_regs[bus.ReadRegister2];
        if (bus.ReadRegister2 == ADDR_W'(ZERO_REG)) begin
            w_rd2 = '0;
        end else if (w_commit && (bus.ReadRegister2 == w_waddr)) begin
            w_rd2 = w_wdata;
        end
    end

    assign bus.ReadData1     = w_rd1;
    assign bus.ReadData2     = w_rd2;
    assign bus.LastWriteData = r_last_data;
    assign bus.LastWriteReg  = r_last_reg;
    assign bus.WriteCount    = r_write_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus pushes expected outputs from a
// behavioural register-file model; a negedge monitor pops and compares.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    localparam int K_RD1  = 0;
    localparam int K_RD2  = 1;
    localparam int K_LWD  = 2;
    localparam int K_LWR  = 3;
    localparam int K_WCNT = 4;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    logic Clk = 1'b0;
    logic Reset = 1'b0;

    always #5 Clk = ~Clk;

    wb_regfile_if bus ();

    wb_regfile dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    chk_t        q[$];
    int          checks = 0;
    int          errors = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    logic [31:0] m_lwd;
    logic [4:0]  m_lwr;

    chk_t        mon_c;
    logic [31:0] mon_act;

    // Monitor: outputs are combinational/registered, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge Clk);
            while (q.size() > 0) begin
                mon_c = q.pop_front();
                case (mon_c.kind)
                    K_RD1:   mon_act = bus.ReadData1;
                    K_RD2:   mon_act = bus.ReadData2;
                    K_LWD:   mon_act = bus.LastWriteData;
                    K_LWR:   mon_act = {27'd0, bus.LastWriteReg};
                    default: mon_act = bus.WriteCount;
                endcase
                checks++;
                if (mon_act !== mon_c.exp) begin
                    errors++;
                    $display("FAIL %s actual=%h expected=%h", mon_c.name, mon_act, mon_c.exp);
                end
            end
        end
    end

    function automatic logic [31:0] m_fmt(input logic [31:0] mem, input logic [1:0] off,
                                          input logic [1:0] ld);
        logic [31:0] v;
        case (ld)
            2'b00: v = mem;
            2'b01: begin
                v = (mem >> (16 * int'(off[1]))) & 32'h0000FFFF;
                if (v >= 32'h00008000) v = v | 32'hFFFF0000;
            end
            2'b10: begin
                v = (mem >> (8 * int'(off))) & 32'h000000FF;
                if (v >= 32'h00000080) v = v | 32'hFFFFFF00;
            end
            default: v = (mem >> (8 * int'(off))) & 32'h000000FF;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic cm,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (cm && a == wa) return wd;
        return m_regs[a];
    endfunction

    task automatic push(input int kind, input logic [31:0] exp, input string name);
        q.push_back('{kind, exp, name});
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt = 32'd0;
        m_lwd = 32'd0;
        m_lwr = 5'd0;
    endtask

    // Called at posedge+1: drive one cycle, queue expectations, advance model.
    task automatic step(input logic rw, input logic mtr, input logic [1:0] ld,
                        input logic jra, input logic jrd, input logic [4:0] ra,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc,
                        input logic [4:0] r1, input logic [4:0] r2, input string tag);
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        cm;
        bus.RegWrite      = rw;
        bus.MemToReg      = mtr;
        bus.LoadData      = ld;
        bus.JrAddress     = jra;
        bus.JrData        = jrd;
        bus.RegAddress    = ra;
        bus.ALUResult     = alu;
        bus.MemReadData   = mem;
        bus.PCAdderResult = pc;
        bus.ReadRegister1 = r1;
        bus.ReadRegister2 = r2;
        wa = jra ? 5'd31 : ra;
        if (jrd)      wd = pc;
        else if (mtr) wd = m_fmt(mem, alu[1:0], ld);
        else          wd = alu;
        cm = Reset && rw && (wa != 5'd0);
        push(K_RD1,  m_read(r1, cm, wa, wd), {tag, ".rd1"});
        push(K_RD2,  m_read(r2, cm, wa, wd), {tag, ".rd2"});
        push(K_LWD,  m_lwd, {tag, ".lastdata"});
        push(K_LWR,  {27'd0, m_lwr}, {tag, ".lastreg"});
        push(K_WCNT, m_cnt, {tag, ".count"});
        @(posedge Clk);
        if (cm) begin
            m_regs[wa] = wd;
            m_lwd      = wd;
            m_lwr      = wa;
            m_cnt      = m_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic idle_read(input logic [4:0] r1, input logic [4:0] r2, input string tag);
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'($urandom_range(0, 31)), $urandom(), $urandom(),
             $urandom(), r1, r2, tag);
    endtask

    logic [1:0]  t3_ld  [5] = '{2'b10, 2'b11, 2'b01, 2'b10, 2'b00};
    logic [1:0]  t3_off [5] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    logic [31:0] t3_exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h0000007F, 32'h80FF7F01};

    initial begin
        logic [31:0] alu;
        logic [4:0]  ra;
        logic        rw;

        model_clear();
        bus.RegWrite = 1'b0; bus.MemToReg = 1'b0; bus.LoadData = 2'b00;
        bus.JrAddress = 1'b0; bus.JrData = 1'b0; bus.RegAddress = 5'd0;
        bus.ALUResult = 32'd0; bus.MemReadData = 32'd0; bus.PCAdderResult = 32'd0;
        bus.ReadRegister1 = 5'd0; bus.ReadRegister2 = 5'd0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;

        // Reset state
        idle_read(5'd5, 5'd31, "reset_state");

        // ALU write with same-cycle bypass, then readback
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 5'd8, 32'hDEADBEEF, $urandom(), $urandom(),
             5'd8, 5'd0, "alu_bypass");
        push(K_RD1, 32'hDEADBEEF, "alu_hold.lit_rd1");
        push(K_LWR, 32'd8, "alu_hold.lit_lastreg");
        push(K_WCNT, 32'd1, "alu_hold.lit_count");
        idle_read(5'd8, 5'd0, "alu_hold");

        // Load formatting sweep into registers 10..14
        for (int k = 0; k < 5; k++) begin
            alu = $urandom();
            alu[1:0] = t3_off[k];
            step(1'b1, 1'b1, t3_ld[k], 1'b0, 1'b0, 5'(10 + k), alu, 32'h80FF7F01, $urandom(),
                 5'(10 + k), 5'd0, $sformatf("load%0d", k));
        end
        for (int k = 0; k < 5; k++) begin
            push(K_RD2, t3_exp[k], $sformatf("load%0d.lit", k));
            idle_read(5'd0, 5'(10 + k), $sformatf("load%0d_rb", k));
        end

        // Link write to r31; RegAddress is ignored
        step(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 5'd3, $urandom(), $urandom(), 32'h00000048,
             5'd31, 5'd3, "link");
        push(K_RD1, 32'h00000048, "link_rb.lit_r31");
        push(K_RD2, 32'h00000000, "link_rb.lit_r3");
        idle_read(5'd31, 5'd3, "link_rb");

        // Write to r0 has no effect
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF, $urandom(), $urandom(),
             5'd0, 5'd0, "r0_write");
        push(K_LWR, 32'd31, "r0_after.lit_lastreg");
        idle_read(5'd0, 5'd31, "r0_after");

        // Counter wrap and dual-port same-address bypass
        bus.RegWrite = 1'b0;
        force dut.r_write_count = 32'hFFFFFFFF;
        #2;
        release dut.r_write_count;
        m_cnt = 32'hFFFFFFFF;
        @(posedge Clk);
        #1;
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 5'd9, 32'hA5A55A5A, $urandom(), $urandom(),
             5'd9, 5'd9, "wrap_write");
        push(K_WCNT, 32'd0, "wrap_after.lit_count");
        idle_read(5'd9, 5'd9, "wrap_after");

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            ra  = 5'($urandom_range(0, 31));
            rw  = ($urandom_range(0, 3) != 0);
            step(rw, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), ra,
                 $urandom(), $urandom(), $urandom(),
                 ($urandom_range(0, 1) == 1) ? ra : 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 2) == 0) ? ra : 5'($urandom_range(0, 31)),
                 $sformatf("rand%0d", n));
        end

        // Mid-run reset: write r5, then async reset with a competing write to r7
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 5'd5, 32'h12345678, $urandom(), $urandom(),
             5'd5, 5'd0, "pre_reset");
        Reset = 1'b0;
        model_clear();
        bus.RegWrite = 1'b1; bus.MemToReg = 1'b0; bus.JrAddress = 1'b0; bus.JrData = 1'b0;
        bus.RegAddress = 5'd7; bus.ALUResult = 32'h0BADF00D;
        bus.ReadRegister1 = 5'd5; bus.ReadRegister2 = 5'd7;
        push(K_RD1, 32'd0, "in_reset.rd1");
        push(K_RD2, 32'd0, "in_reset.rd2");
        push(K_WCNT, 32'd0, "in_reset.count");
        push(K_LWD, 32'd0, "in_reset.lastdata");
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        idle_read(5'd7, 5'd5, "post_reset");

        repeat (2) @(negedge Clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the pipeline: consumes the MEM/WB pipeline-register outputs, selects and formats the write-back value, and commits it to the 32-entry general register file.
- Provides two read ports to the decode stage, with write-through bypass, so a same-cycle read returns the value being written.
- Keeps registered "last commit" observation outputs and a commit counter for the board display and the bench.

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 5, register address width.
- NREGS, 32, number of registers; register 0 is hardwired to zero.
- LINK_REG, 31, destination register forced when JrAddress=1.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- MemReadData  in  32  word loaded from data memory.
- ALUResult  in  32  ALU result; bits [1:0] give the byte offset for sub-word loads.
- RegAddress  in  5  destination register.
- PCAdderResult  in  32  link value for jal/jalr.
- RegWrite  in  1  commit enable.
- MemToReg  in  1  1 = memory data, 0 = ALU result.
- LoadData  in  2  load format: 00 word, 01 signed half, 10 signed byte, 11 unsigned byte.
- JrAddress  in  1  force the destination to LINK_REG.
- JrData  in  1  write data = PCAdderResult.
- ReadRegister1, ReadRegister2  in  5 each  read addresses.
- ReadData1, ReadData2  out  32 each  read data (combinational).
- LastWriteData  out  32  registered copy of the last committed data.
- LastWriteReg  out  5  registered copy of the last committed address.
- WriteCount  out  32  number of committed writes.

Behaviour:
- Reset low, asynchronous: all NREGS registers, LastWriteData, LastWriteReg and WriteCount go to 0 immediately and stay 0 while Reset is low.
- ReadData1/ReadData2 are 0 during reset, because the register contents are 0.
- Destination: WAddr = JrAddress ? LINK_REG : RegAddress.
- Load formatting (little-endian, offset o = ALUResult[1:0]):
  - 00: MemReadData unchanged.
  - 01: halfword selected by o[1], sign-extended; o[0] is ignored.
  - 10: byte o, sign-extended.
  - 11: byte o, zero-extended.
- Data select, in priority order: JrData → PCAdderResult; else MemToReg → formatted load; else ALUResult. LoadData is ignored when MemToReg=0.
- Commit condition: Reset high, RegWrite=1 and WAddr≠0.
  - On the rising edge, reg[WAddr] ← WData.
  - Same edge: LastWriteData ← WData, LastWriteReg ← WAddr, WriteCount ← WriteCount+1.
  - WriteCount wraps from 0xFFFFFFFF to 0.
  - Latency: 1 edge.
- Write to register 0 (RegWrite=1, WAddr=0): no state change at all; the counter and Last* hold.
- Read port i:
  - ReadRegister=0 → 0.
  - Commit condition true and ReadRegister=WAddr → WData (bypass).
  - Otherwise → reg[ReadRegister].
  - Both ports may hit the same address, or the bypass, in the same cycle.
- RegWrite=0: all state holds regardless of the other inputs.
- Reset asserted on the same edge as a commit: reset wins and the write is lost.

Decomposition:
- Shared package holds:
  - LoadData encodings: LD_WORD=2'b00, LD_HALF=2'b01, LD_BYTE=2'b10, LD_UBYTE=2'b11.
  - LINK_REG and ZERO_REG constants.
  - DATA_W / ADDR_W defaults.
- Sub-module load_formatter: purely combinational (MemReadData, offset, LoadData → formatted word). It is the natural split and is unit-testable alone.
- Register array, bypass, commit logic and counters stay in wb_regfile.

Test Plan:
1. Reset low mid-run after writing reg 5 = 0x12345678 → ReadData1 for reg 5 reads 0 immediately without a clock; WriteCount=0.
2. RegWrite=1, MemToReg=0, RegAddress=8, ALUResult=0xDEADBEEF:
   - Same cycle: ReadRegister1=8 → ReadData1=0xDEADBEEF via bypass.
   - After the edge: reg 8 holds it, LastWriteReg=8, WriteCount=1.
3. MemToReg=1, MemReadData=0x80FF7F01, sweeping LoadData/offset:
   - LD_BYTE, o=3 → 0xFFFFFF80.
   - LD_UBYTE, o=3 → 0x00000080.
   - LD_HALF, o=2 → 0xFFFF80FF.
   - LD_BYTE, o=1 → 0x0000007F.
   - LD_WORD → 0x80FF7F01.
4. JrAddress=1, JrData=1, PCAdderResult=0x00000048, RegAddress=3 → reg 31 = 0x48 and reg 3 unchanged.
5. RegWrite=1, RegAddress=0, ALUResult=0xFFFFFFFF → ReadData for reg 0 stays 0; WriteCount and LastWrite* unchanged.
6. Force WriteCount to 0xFFFFFFFF, then commit one write → WriteCount=0; simultaneous read of the same address on both ports returns identical data.
